// File: rtl/serial_adder.sv
// Bit-serial adder: WIDTH-bit a + b + cin, one bit per clock, LSB first, start/busy/done handshake.
// Optional macro SERIAL_ADDER_SUB_EN adds a sub input for a - b.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] s_q;
  logic             c_q;

  logic             ha0_s_c;
  logic             ha0_c_c;
  logic             ha1_s_c;
  logic             ha1_c_c;
  logic             carry_nxt_c;
  logic             last_c;
  logic [WIDTH-1:0] b_load_c;
  logic             carry_load_c;

  // Full add from two half adders; the carry flip-flop closes the loop.
  always_comb begin
    ha0_s_c     = a_sr_q[0] ^ b_sr_q[0];
    ha0_c_c     = a_sr_q[0] & b_sr_q[0];
    ha1_s_c     = ha0_s_c ^ carry_q;
    ha1_c_c     = ha0_s_c & carry_q;
    carry_nxt_c = ha0_c_c | ha1_c_c;
    last_c      = (cnt_q == CNT_W'(WIDTH - 1));
  end

  // Subtract loads ~b with a forced carry of 1 (two's complement).
  always_comb begin
    b_load_c     = b;
    carry_load_c = cin;
`ifdef SERIAL_ADDER_SUB_EN
    if (sub) begin
      b_load_c     = ~b;
      carry_load_c = 1'b1;
    end
`endif
  end

  // Operand A register doubles as the sum shift register: sum bits enter at the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      s_q     <= '0;
      c_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sr_q  <= a;
            b_sr_q  <= b_load_c;
            carry_q <= carry_load_c;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_sr_q  <= {ha1_s_c, a_sr_q[WIDTH-1:1]};
          b_sr_q  <= {1'b0, b_sr_q[WIDTH-1:1]};
          carry_q <= carry_nxt_c;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (last_c) begin
            s_q     <= {ha1_s_c, a_sr_q[WIDTH-1:1]};
            c_q     <= carry_nxt_c;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign s    = s_q;
  assign c    = c_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: WIDTH=8 instance under random/directed traffic, plus a WIDTH=4 instance.
module tb_serial_adder;

  localparam int unsigned W = 8;
`ifdef SERIAL_ADDER_SUB_EN
  localparam bit HAS_SUB = 1'b1;
`else
  localparam bit HAS_SUB = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] s;
  logic         c;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub;
  logic         sub4;
`endif

  logic         start4;
  logic [3:0]   a4;
  logic [3:0]   b4;
  logic         cin4;
  logic         busy4;
  logic         done4;
  logic [3:0]   s4;
  logic         c4;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int           acc;
    int           dc;
    logic [W-1:0] s;
    logic         c;
  } exp_t;

  exp_t q[$];
  logic [W-1:0] last_s = '0;
  logic         last_c = 1'b0;

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .s(s), .c(c)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub4),
`endif
    .busy(busy4), .done(done4), .s(s4), .c(c4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: compares busy/done/s/c against the scoreboard every cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_done", 64'(done), 64'd0);
      chk("reset_s", 64'(s), 64'd0);
      chk("reset_c", 64'(c), 64'd0);
      last_s = '0;
      last_c = 1'b0;
    end else begin
      logic exp_busy;
      exp_busy = 1'b0;
      foreach (q[i]) if (q[i].acc <= cyc && cyc < q[i].dc) exp_busy = 1'b1;
      chk("busy", 64'(busy), 64'(exp_busy));
      if (q.size() > 0 && q[0].dc == cyc) begin
        exp_t e;
        e = q.pop_front();
        chk("done_pulse", 64'(done), 64'd1);
        chk("sum", 64'(s), 64'(e.s));
        chk("carry", 64'(c), 64'(e.c));
        last_s = e.s;
        last_c = e.c;
      end else begin
        chk("no_done", 64'(done), 64'd0);
        chk("s_hold", 64'(s), 64'(last_s));
        chk("c_hold", 64'(c), 64'(last_c));
      end
    end
  end

  // Advance one clock; scramble operands afterwards since they must not matter once captured.
  task automatic tick();
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    cin   = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
    sub   = 1'($urandom);
`endif
  endtask

  // Request an operation for the coming edge; the model result is queued only if it will be accepted.
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci, input logic sb);
    logic [W:0] full;
    exp_t       e;
    a     = av;
    b     = bv;
    cin   = ci;
    start = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
    sub   = sb;
`endif
    if (HAS_SUB && sb) full = {1'b0, av} + {1'b0, ~bv} + (W+1)'(1);
    else               full = {1'b0, av} + {1'b0, bv} + (W+1)'(ci);
    if (!busy) begin
      e.acc = cyc + 1;
      e.dc  = cyc + 1 + int'(W);
      e.s   = full[W-1:0];
      e.c   = full[W];
      q.push_back(e);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50 && busy; i++) tick();
    chk("idle_timeout", 64'(busy), 64'd0);
  endtask

  // Sequential check of the 4-bit instance: result and latency.
  task automatic run4(input logic [3:0] av, input logic [3:0] bv, input logic ci);
    logic [4:0] full;
    int         n;
    full   = {1'b0, av} + {1'b0, bv} + 5'(ci);
    a4     = av;
    b4     = bv;
    cin4   = ci;
    start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    a4     = 4'($urandom);
    b4     = 4'($urandom);
    n      = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done4) begin
        n = i;
        break;
      end
    end
    chk("w4_latency", 64'(n), 64'd5);
    chk("w4_sum", 64'(s4), 64'(full[3:0]));
    chk("w4_carry", 64'(c4), 64'(full[4]));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    cin    = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub    = 1'b0;
    sub4   = 1'b0;
`endif
    start4 = 1'b0;
    a4     = '0;
    b4     = '0;
    cin4   = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (20) tick();

    // Wrap to zero with carry out.
    issue(8'hFF, 8'h01, 1'b0, 1'b0);
    tick();
    wait_idle();
    tick();

    // Back-to-back: restart in the done cycle.
    issue(8'h7F, 8'h80, 1'b1, 1'b0);
    tick();
    wait_idle();
    issue(8'h12, 8'h34, 1'b0, 1'b0);
    tick();
    wait_idle();
    tick();

    // Start during an operation is ignored.
    issue(8'h3C, 8'h0F, 1'b1, 1'b0);
    repeat (3) tick();
    issue(8'hAA, 8'h55, 1'b0, 1'b0);
    tick();
    wait_idle();
    tick();

    // Reset mid-operation aborts without a done pulse.
    issue(8'h81, 8'h92, 1'b1, 1'b0);
    repeat (4) tick();
    rst_n = 1'b0;
    q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    issue(8'h21, 8'h43, 1'b1, 1'b0);
    tick();
    wait_idle();
    tick();

    if (HAS_SUB) begin
      issue(8'h05, 8'h07, 1'b0, 1'b1);
      tick();
      wait_idle();
      tick();
    end

    // Random traffic: gaps, back-to-back starts and ignored starts mixed.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0)
        issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      tick();
    end
    wait_idle();
    repeat (2) tick();
    chk("scoreboard_empty", 64'(q.size()), 64'd0);

    run4(4'hF, 4'hF, 1'b1);
    for (int i = 0; i < 10; i++) run4(4'($urandom), 4'($urandom), 1'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
